keypad_scan: RTL

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_pkg.sv | 30 +++
 rtl/keypad_row_sync.sv | 26 ++
 rtl/keypad_scan.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types for the 4x4 keypad scanner: FSM states, key code width,
// and the per-scan result reported at the end of every full scan.
package keypad_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_t;

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } scan_kind_t;

    typedef struct packed {
        scan_kind_t       kind;
        logic [KEY_W-1:0] code;
    } scan_res_t;

    // Number of active-low rows in a 4-bit row sample.
    function automatic logic [2:0] count_low(input logic [3:0] rows);
        return {2'b00, ~rows[0]} + {2'b00, ~rows[1]} + {2'b00, ~rows[2]} + {2'b00, ~rows[3]};
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous, pulled-up row returns.
// Resets to all ones (no key) so a reset never looks like a press.
module keypad_row_sync (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta_r;
    logic [3:0] sync_r;

    // Two-stage capture of the row inputs into the CLK domain.
    always_ff @(posedge CLK) begin
        if (RST) begin
            meta_r <= 4'b1111;
            sync_r <= 4'b1111;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with ghost rejection, press/release debounce
// and a single-entry key register with overrun flag.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat while a key is held).
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 12000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 250
) (
    input  logic             CLK,
    input  logic             RST,
    output logic [3:0]       COL,
    input  logic [3:0]       ROW,
    output logic [KEY_W-1:0] KEY,
    output logic             KEY_VALID,
    input  logic             KEY_ACK,
    output logic             OVERRUN
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

    // The debounce FSM assumes at least one confirming scan after the first.
    if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 2 || REPEAT_SCANS < 1) begin : g_bad_param
        $error("keypad_scan: parameter out of range");
    end

    logic [3:0]       row_sync_s;
    logic [DIV_W-1:0] div_cnt_r;
    logic [1:0]       col_idx_r;
    logic [3:0]       col_r;
    logic [1:0]       hits_r;
    logic [KEY_W-1:0] code_r;
    logic             dwell_last_s;
    logic             strobe_s;
    logic [2:0]       col_low_s;
    logic [1:0]       row_idx_s;
    logic [1:0]       hits_base_s;
    logic [2:0]       hits_sum_s;
    logic [1:0]       hits_sat_s;
    logic [KEY_W-1:0] code_next_s;
    scan_res_t        scan_res_s;
    logic             key_hit_s;

    kp_state_t        state_r, state_next_s;
    logic [KEY_W-1:0] cand_r, cand_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic             emit_s;
    logic [KEY_W-1:0] key_r;
    logic             key_valid_r;
    logic             overrun_r;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SCANS + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS - 1);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
    logic [REP_W-1:0] rep_cnt_r, rep_next_s;
`endif

    keypad_row_sync u_row_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (ROW),
        .q   (row_sync_s)
    );

    assign dwell_last_s = (div_cnt_r == DIV_LAST);
    assign strobe_s     = dwell_last_s && (col_idx_r == 2'd3);

    // Dwell counter and column rotation; COL is kept as its own register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            div_cnt_r <= '0;
            col_idx_r <= 2'd0;
            col_r     <= 4'b1110;
        end else if (dwell_last_s) begin
            div_cnt_r <= '0;
            col_idx_r <= col_idx_r + 2'd1;
            col_r     <= {col_r[2:0], col_r[3]};
        end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
        end
    end

    // Row index of the single low row in this column's sample.
    always_comb begin
        row_idx_s = 2'd0;
        case (row_sync_s)
            4'b1110: row_idx_s = 2'd0;
            4'b1101: row_idx_s = 2'd1;
            4'b1011: row_idx_s = 2'd2;
            4'b0111: row_idx_s = 2'd3;
            default: row_idx_s = 2'd0;
        endcase
    end

    // Fold this column's sample into the running scan result (column 0 starts afresh).
    always_comb begin
        col_low_s   = count_low(row_sync_s);
        hits_base_s = (col_idx_r == 2'd0) ? 2'd0 : hits_r;
        hits_sum_s  = {1'b0, hits_base_s} + col_low_s;
        hits_sat_s  = (hits_sum_s >= 3'd2) ? 2'd2 : hits_sum_s[1:0];
        if (col_low_s == 3'd1) begin
            code_next_s = {col_idx_r, row_idx_s};
        end else if (col_idx_r == 2'd0) begin
            code_next_s = 4'h0;
        end else begin
            code_next_s = code_r;
        end
        scan_res_s.code = code_next_s;
        case (hits_sat_s)
            2'd0:    scan_res_s.kind = RES_NONE;
            2'd1:    scan_res_s.kind = RES_SINGLE;
            default: scan_res_s.kind = RES_MULTI;
        endcase
        // Ghosting: several low rows are indistinguishable from no key.
        key_hit_s = (scan_res_s.kind == RES_SINGLE);
    end

    // Partial-scan accumulator, updated only on the last dwell cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hits_r <= 2'd0;
            code_r <= 4'h0;
        end else if (dwell_last_s) begin
            hits_r <= hits_sat_s;
            code_r <= code_next_s;
        end else begin
            hits_r <= hits_r;
            code_r <= code_r;
        end
    end

    // Debounce FSM state registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            cand_r  <= 4'h0;
            cnt_r   <= '0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_r <= '0;
`endif
        end else begin
            state_r <= state_next_s;
            cand_r  <= cand_next_s;
            cnt_r   <= cnt_next_s;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_r <= rep_next_s;
`endif
        end
    end

    // Debounce FSM next-state and emit decision, evaluated once per full scan.
    always_comb begin
        state_next_s = state_r;
        cand_next_s  = cand_r;
        cnt_next_s   = cnt_r;
        emit_s       = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_next_s   = rep_cnt_r;
`endif
        if (strobe_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (key_hit_s) begin
                        state_next_s = ST_DEBOUNCE;
                        cand_next_s  = scan_res_s.code;
                        cnt_next_s   = CNT_ONE;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_DEBOUNCE: begin
                    if (!key_hit_s) begin
                        state_next_s = ST_IDLE;
                        cnt_next_s   = '0;
                    end else if (scan_res_s.code != cand_r) begin
                        cand_next_s  = scan_res_s.code;
                        cnt_next_s   = CNT_ONE;
                    end else if (cnt_r == DEB_LAST) begin
                        state_next_s = ST_PRESSED;
                        cnt_next_s   = '0;
                        emit_s       = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                        rep_next_s   = '0;
`endif
                    end else begin
                        cnt_next_s   = cnt_r + CNT_ONE;
                    end
                end
                ST_PRESSED: begin
                    if (!key_hit_s) begin
                        state_next_s = ST_RELEASE;
                        cnt_next_s   = CNT_ONE;
                    end else begin
                        state_next_s = ST_PRESSED;
`ifdef KEYPAD_REPEAT_EN
                        if (scan_res_s.code == cand_r) begin
                            if (rep_cnt_r == REP_LAST) begin
                                rep_next_s = '0;
                                emit_s     = 1'b1;
                            end else begin
                                rep_next_s = rep_cnt_r + REP_ONE;
                            end
                        end else begin
                            rep_next_s = rep_cnt_r;
                        end
`endif
                    end
                end
                ST_RELEASE: begin
                    if (key_hit_s) begin
                        state_next_s = ST_PRESSED;
                        cnt_next_s   = '0;
`ifdef KEYPAD_REPEAT_EN
                        rep_next_s   = '0;
`endif
                    end else if (cnt_r == DEB_LAST) begin
                        state_next_s = ST_IDLE;
                        cnt_next_s   = '0;
                    end else begin
                        cnt_next_s   = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = '0;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Key register: an emit loads only when the slot is free or being acked.
    always_ff @(posedge CLK) begin
        if (RST) begin
            key_r       <= 4'h0;
            key_valid_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else if (emit_s) begin
            if (!key_valid_r || KEY_ACK) begin
                key_r       <= cand_r;
                key_valid_r <= 1'b1;
            end else begin
                overrun_r   <= 1'b1;
            end
        end else if (KEY_ACK && key_valid_r) begin
            key_valid_r <= 1'b0;
        end else begin
            key_valid_r <= key_valid_r;
        end
    end

    assign COL       = col_r;
    assign KEY       = key_r;
    assign KEY_VALID = key_valid_r;
    assign OVERRUN   = overrun_r;

endmodule
